ram_param: RTL
==============

# ram_param

Parametrised single-clock RAM with a separate write port and a read port. The read port offers both a combinational output and a registered, handshaked output. After every reset an internal sequencer fills the whole array with a selectable pattern before it accepts accesses, so no initial block is needed and contents are restored on demand. It is the general-purpose storage block for the datapath and replaces fixed 8x64 arrays.

## Interface
- DATA_W, 8: data width in bits.
- ADDR_W, 8: address width in bits.
- DEPTH, 64: number of words; 1 <= DEPTH <= 2**ADDR_W.
- INIT_MODE, 1: reset fill pattern.
  - 0: all zero.
  - 1: word[i] = (2*i) mod 2**DATA_W.
- RDW_MODE, 0: registered read of the address written in the same cycle.
  - 0: returns old data.
  - 1: returns new data.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- we  in  1  write request.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr  in  ADDR_W  read address, shared by both read outputs.
- rd_en  in  1  registered-read request.
- rdata_async  out  DATA_W  combinational read of word[raddr].
- rdata_q  out  DATA_W  registered read data.
- rvalid  out  1  rdata_q valid strobe.
- busy  out  1  init fill in progress; all accesses are ignored while high.

## Operation
- The sequencer has two states, INIT and READY, and a fill counter cnt of ADDR_W bits.
- rst=1 at an edge:
  - state goes to INIT and cnt to 0.
  - busy=1, rvalid=0, rdata_q=0.
  - No array write occurs while rst is held.
- INIT with rst=0:
  - Each edge writes pattern(cnt) to word[cnt], then cnt increments.
  - The edge that writes word[DEPTH-1] moves state to READY and clears busy.
  - cnt does not wrap.
- READY:
  - we=1 and waddr<DEPTH writes wdata to word[waddr] at the edge.
  - we=1 with waddr>=DEPTH is dropped, with no aliasing.
  - rd_en=1 loads rdata_q at the edge: word[raddr] if raddr<DEPTH, else 0. rvalid=1 for that cycle.
  - rd_en=0 sets rvalid=0 and holds rdata_q.
- rdata_async:
  - Equals word[raddr] when raddr<DEPTH and busy=0; otherwise 0.
  - It reflects a write on the same address in the cycle after the write edge.
- Registered read with raddr==waddr<DEPTH at the same edge: RDW_MODE selects old data (0) or new data (1).
- In INIT, we and rd_en are ignored: no write, rvalid stays 0, rdata_q holds 0.
- A reset mid-fill or mid-operation restarts the fill from cnt=0 and overwrites all user data.
- Pattern arithmetic is computed at DATA_W bits and truncated. For example, with DATA_W=8 and DEPTH=256, word[200]=144.
- Before the first reset, contents and outputs are undefined. The integrator must assert rst at least one cycle.

## Timing
- Reset released before edge E1: fill writes happen at edges E1..E_DEPTH, and busy falls after E_DEPTH.
- busy is high for exactly DEPTH cycles after the last rst=1 edge.
- Write latency: 1 edge. The written data is visible on rdata_async in the following cycle.
- Registered read latency: 1 cycle. rd_en sampled at edge N gives rdata_q/rvalid valid from N until edge N+1.
- Back-to-back reads at one per cycle are supported; rvalid stays high continuously.
- The first access is accepted at the first edge where busy=0 before that edge, i.e. edge E_DEPTH+1.

## Test plan
- Reset and fill, defaults:
  - Stimulus: rst for 1 cycle, then idle.
  - Required: busy high for exactly 64 cycles.
  - Afterwards, sweeping raddr 0..63 gives rdata_async = 0,2,...,126, and raddr 64..255 gives 0.
- Write/read:
  - Stimulus: after the fill, write 0xA5 to address 10, then rd_en at address 10.
  - Required: rdata_async=0xA5 in the next cycle; rdata_q=0xA5 with rvalid=1 one cycle after rd_en.
  - Also: a write to address 70 is dropped and word[6] stays 12.
- Read during write:
  - Stimulus: same edge we=1, rd_en=1, waddr=raddr=5, wdata=0x3C.
  - Required: RDW_MODE=0 gives rdata_q=10; RDW_MODE=1 gives rdata_q=0x3C.
  - In both modes a later read gives 0x3C.
- Access during busy:
  - Stimulus: we=1 and rd_en=1 pulsed during the fill.
  - Required: rvalid=0, rdata_q=0, and word contents equal to the pattern after the fill.
- Reset mid-operation:
  - Stimulus: write 0xFF to address 3, then rst at fill cycle 20 of a second fill.
  - Required: busy restarts its 64-cycle count, and word[3]=6 afterwards.
- Parameters INIT_MODE=0, DATA_W=16, ADDR_W=4, DEPTH=16:
  - Required: busy lasts 16 cycles and all words read 0.
  - Back-to-back reads of addresses 0..15 give rvalid high for 16 consecutive cycles.

Source files
------------

// File: rtl/ram_param_if.sv
// Bus bundle for ram_param: write port, shared read address and both read outputs.
// The master drives requests; the slave (the RAM) returns read data and status.
interface ram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr;
  logic              rd_en;
  logic [DATA_W-1:0] rdata_async;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid;
  logic              busy;

  modport master (
    output we, waddr, wdata, raddr, rd_en,
    input  rdata_async, rdata_q, rvalid, busy
  );

  modport slave (
    input  we, waddr, wdata, raddr, rd_en,
    output rdata_async, rdata_q, rvalid, busy
  );
endinterface

// File: rtl/ram_param.sv
// Parametrised single-clock RAM with combinational and registered/handshaked read ports.
// After every reset a sequencer fills the array with a pattern; accesses are ignored until it finishes.
module ram_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 64,
  parameter int INIT_MODE = 1,
  parameter int RDW_MODE  = 0
) (
  input logic        clk,
  input logic        rst,
  ram_param_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Fill value for word idx, computed at DATA_W bits and truncated.
  function automatic logic [DATA_W-1:0] fill_pattern(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = DATA_W'(idx);
    if (INIT_MODE == 1) begin
      return val << 1'b1;
    end else begin
      return {DATA_W{1'b0}};
    end
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W-1:0];
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [0:0]        state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              busy_r;
  logic [DATA_W-1:0] rdata_q_r;
  logic              rvalid_r;

  logic              fill_last_s;
  logic              waddr_ok_s;
  logic              raddr_ok_s;
  logic              user_we_s;
  logic              user_rd_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] async_s;

  assign fill_last_s = (cnt_r == LAST_C);
  assign waddr_ok_s  = ({1'b0, bus.waddr} < DEPTH_C);
  assign raddr_ok_s  = ({1'b0, bus.raddr} < DEPTH_C);
  assign user_we_s   = !rst && (state_r == ST_READY) && bus.we && waddr_ok_s;
  assign user_rd_s   = !rst && (state_r == ST_READY) && bus.rd_en;

  // Single write port: the fill sequencer owns it in INIT, the user in READY.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = {IDX_W{1'b0}};
    wr_data_s = {DATA_W{1'b0}};
    if (rst) begin
      wr_en_s = 1'b0;
    end else if (state_r == ST_INIT) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = to_idx(cnt_r);
      wr_data_s = fill_pattern(cnt_r);
    end else if (user_we_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = to_idx(bus.waddr);
      wr_data_s = bus.wdata;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Array storage; no reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= wr_data_s;
    end
  end

  // Next registered read value, with optional write-through on an address collision.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    if (!raddr_ok_s) begin
      rd_data_s = {DATA_W{1'b0}};
    end else if ((RDW_MODE == 1) && user_we_s && (bus.waddr == bus.raddr)) begin
      rd_data_s = bus.wdata;
    end else begin
      rd_data_s = mem_r[to_idx(bus.raddr)];
    end
  end

  // Combinational read port, forced to zero while filling or out of range.
  always_comb begin
    async_s = {DATA_W{1'b0}};
    if (!busy_r && raddr_ok_s) begin
      async_s = mem_r[to_idx(bus.raddr)];
    end else begin
      async_s = {DATA_W{1'b0}};
    end
  end

  // Fill sequencer: INIT walks cnt over every word once, then parks in READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_INIT;
      cnt_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (fill_last_s) begin
            state_r <= ST_READY;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + ADDR_W'(1'b1);
          end
        end
        ST_READY: begin
          state_r <= ST_READY;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_INIT;
          cnt_r   <= {ADDR_W{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Registered read port: rvalid strobes for each accepted rd_en, rdata_q holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q_r <= {DATA_W{1'b0}};
      rvalid_r  <= 1'b0;
    end else if (user_rd_s) begin
      rdata_q_r <= rd_data_s;
      rvalid_r  <= 1'b1;
    end else begin
      rvalid_r <= 1'b0;
    end
  end

  assign bus.rdata_async = async_s;
  assign bus.rdata_q     = rdata_q_r;
  assign bus.rvalid      = rvalid_r;
  assign bus.busy        = busy_r;

  ram_param_chk #(.DATA_W(DATA_W)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .busy        (busy_r),
    .rvalid      (rvalid_r),
    .rdata_q     (rdata_q_r),
    .rdata_async (async_s)
  );
endmodule

// Output-level invariants of ram_param.
module ram_param_chk #(
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  input logic              busy,
  input logic              rvalid,
  input logic [DATA_W-1:0] rdata_q,
  input logic [DATA_W-1:0] rdata_async
);
  a_reset_state: assert property (@(posedge clk)
    rst |=> (busy && !rvalid && (rdata_q == {DATA_W{1'b0}})));

  a_busy_async_zero: assert property (@(posedge clk) disable iff (rst)
    busy |-> (rdata_async == {DATA_W{1'b0}}));

  a_no_rvalid_when_busy: assert property (@(posedge clk) disable iff (rst)
    rvalid |-> !busy);
endmodule
